// File: rtl/voice_ctrl_pkg.sv
// Shared definitions for the voice controller: envelope states, key encoding, gain limits.
package voice_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_t;

  // Bit 4 set marks "no key"; valid keys are 0..15.
  typedef logic [4:0] key_t;
  localparam key_t       KEY_NONE = 5'b1_0000;
  localparam logic [7:0] GAIN_MAX = 8'd255;

  function automatic key_t lowest_key(input logic [15:0] pressed);
    key_t k;
    k = KEY_NONE;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pressed[i] && k[4]) k = key_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/voice_ctrl_scanner.sv
// Keypad column scanner with full-scan debounce; presents the committed key and its valid flag.
module kpyd_scanner
  import voice_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 48,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_48kHz,
  input  logic       rst_n,
  input  logic [3:0] kpyd_row_i,
  output logic [3:0] kpyd_col_o,
  output logic [3:0] key_o,
  output logic       key_valid_o
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [15:0]   scan_q;
  logic [15:0]   scan_d;
  key_t          cand;
  key_t          prev_q;
  logic [CW-1:0] stable_q;
  logic          dwell_end;

  assign dwell_end = (dwell_q == DW'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_q;
    for (int unsigned r = 0; r < 4; r++) begin
      scan_d[{r[1:0], col_q}] = ~kpyd_row_i[r];
    end
  end

  assign cand = lowest_key(scan_d);

  always_ff @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      col_q       <= '0;
      kpyd_col_o  <= 4'b1110;
      scan_q      <= '0;
      prev_q      <= KEY_NONE;
      stable_q    <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
    end else begin
      if (dwell_end) begin
        dwell_q    <= '0;
        col_q      <= col_q + 2'd1;
        kpyd_col_o <= {kpyd_col_o[2:0], kpyd_col_o[3]};
        scan_q     <= scan_d;
        if (col_q == 2'd3) begin
          prev_q <= cand;
          if (cand != prev_q) begin
            stable_q <= CW'(1);
          end else if (stable_q != CW'(DEBOUNCE_SCANS)) begin
            stable_q <= stable_q + 1'b1;
          end
        end
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
      // Stable count holds at its limit, so the commit re-loads the same candidate until it changes.
      if (stable_q == CW'(DEBOUNCE_SCANS)) begin
        key_valid_o <= (prev_q != KEY_NONE);
        key_o       <= prev_q[3:0];
      end
    end
  end

endmodule

// File: rtl/voice_ctrl.sv
// Voice controller top: keypad scanner feeding an attack/sustain/release gain envelope.
module voice_ctrl
  import voice_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 48,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned ATTACK_STEP    = 1,
  parameter int unsigned RELEASE_STEP   = 1
) (
  input  logic       clk_48kHz,
  input  logic       rst_n,
  input  logic [3:0] kpyd_row_i,
  output logic [3:0] kpyd_col_o,
  output logic [3:0] freq_o,
  output logic       note_on_o,
  output logic [7:0] gain_o,
  output logic       busy_o
);

  logic [3:0] key;
  logic       key_valid;
  env_state_t state_q;
  env_state_t state_d;
  logic [7:0] gain_d;
  logic [3:0] freq_d;
  logic [8:0] gain_sum;
  logic [7:0] gain_up;
  logic [7:0] gain_dn;

  kpyd_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk_48kHz  (clk_48kHz),
    .rst_n      (rst_n),
    .kpyd_row_i (kpyd_row_i),
    .kpyd_col_o (kpyd_col_o),
    .key_o      (key),
    .key_valid_o(key_valid)
  );

  assign note_on_o = key_valid;

  assign gain_sum = {1'b0, gain_o} + 9'(ATTACK_STEP);
  assign gain_up  = (gain_sum > 9'(GAIN_MAX)) ? GAIN_MAX : gain_sum[7:0];
  assign gain_dn  = (gain_o > 8'(RELEASE_STEP)) ? (gain_o - 8'(RELEASE_STEP)) : '0;

  always_comb begin
    state_d = state_q;
    gain_d  = gain_o;
    freq_d  = freq_o;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          freq_d  = key;
          state_d = ATTACK;
        end
      end
      ATTACK: begin
        if (!key_valid) begin
          state_d = RELEASE;
        end else begin
          freq_d = key;
          gain_d = gain_up;
          if (gain_up == GAIN_MAX) state_d = SUSTAIN;
        end
      end
      SUSTAIN: begin
        gain_d = GAIN_MAX;
        if (!key_valid) state_d = RELEASE;
        else            freq_d  = key;
      end
      RELEASE: begin
        if (key_valid) begin
          freq_d  = key;
          state_d = ATTACK;
        end else begin
          gain_d = gain_dn;
          if (gain_dn == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gain_o  <= '0;
      freq_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_o  <= gain_d;
      freq_o  <= freq_d;
      busy_o  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_voice_ctrl.sv
// Self-checking bench for voice_ctrl: cycle model of scan/debounce/envelope plus directed literal checks.
module tb_voice_ctrl;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int AS   = 1;
  localparam int RS   = 5;
  localparam int NONE = 16;
  localparam int PH_IDLE    = 0;
  localparam int PH_ATTACK  = 1;
  localparam int PH_SUSTAIN = 2;
  localparam int PH_RELEASE = 3;

  logic        clk_48kHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic [3:0]  kpyd_row_i;
  logic [3:0]  kpyd_col_o;
  logic [3:0]  freq_o;
  logic        note_on_o;
  logic [7:0]  gain_o;
  logic        busy_o;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad   = 0;

  voice_ctrl #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB),
    .ATTACK_STEP   (AS),
    .RELEASE_STEP  (RS)
  ) dut (
    .clk_48kHz (clk_48kHz),
    .rst_n     (rst_n),
    .kpyd_row_i(kpyd_row_i),
    .kpyd_col_o(kpyd_col_o),
    .freq_o    (freq_o),
    .note_on_o (note_on_o),
    .gain_o    (gain_o),
    .busy_o    (busy_o)
  );

  always #5 clk_48kHz = ~clk_48kHz;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kpyd_row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kpyd_col_o[c] && pressed[r*4+c]) kpyd_row_i[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int          m_n, m_prev, m_cnt, m_commit, m_pend_key, m_phase, m_gain, m_freq;
  bit          m_pend;
  logic [15:0] m_scan;

  task automatic model_reset();
    m_n = 0; m_prev = NONE; m_cnt = 0; m_commit = NONE;
    m_pend = 0; m_pend_key = NONE;
    m_phase = PH_IDLE; m_gain = 0; m_freq = 0; m_scan = '0;
  endtask

  task automatic model_step();
    int  col, cand;
    bit  valid;
    valid = (m_commit != NONE);
    case (m_phase)
      PH_IDLE:
        if (valid) begin m_freq = m_commit; m_phase = PH_ATTACK; end
      PH_ATTACK:
        if (!valid) m_phase = PH_RELEASE;
        else begin
          m_freq = m_commit;
          m_gain = (m_gain + AS > 255) ? 255 : m_gain + AS;
          if (m_gain == 255) m_phase = PH_SUSTAIN;
        end
      PH_SUSTAIN:
        if (!valid) m_phase = PH_RELEASE;
        else m_freq = m_commit;
      default:
        if (valid) begin m_freq = m_commit; m_phase = PH_ATTACK; end
        else begin
          m_gain = (m_gain - RS < 0) ? 0 : m_gain - RS;
          if (m_gain == 0) m_phase = PH_IDLE;
        end
    endcase
    if (m_pend) begin m_commit = m_pend_key; m_pend = 0; end
    col = (m_n / SD) % 4;
    if (m_n % SD == SD - 1) begin
      for (int r = 0; r < 4; r++) m_scan[r*4+col] = pressed[r*4+col];
      if (col == 3) begin
        cand = NONE;
        for (int k = 15; k >= 0; k--) if (m_scan[k]) cand = k;
        if (cand == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
        else m_cnt = 1;
        m_prev = cand;
        if (m_cnt == DB) begin m_pend = 1; m_pend_key = cand; end
      end
    end
    m_n++;
  endtask

  always @(posedge clk_48kHz or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_48kHz);
      #1;
      check("col",     kpyd_col_o, 15 ^ (1 << ((m_n / SD) % 4)));
      check("freq",    freq_o,     m_freq);
      check("note_on", note_on_o,  (m_commit != NONE) ? 1 : 0);
      check("gain",    gain_o,     m_gain);
      check("busy",    busy_o,     (m_phase != PH_IDLE) ? 1 : 0);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk_48kHz);
  endtask

  initial begin
    logic [3:0] exp_cols [4];
    int n;
    exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset values
    rst_n = 1'b0;
    hold(3);
    check("rst_col",   kpyd_col_o, 4'b1110);
    check("rst_gain",  gain_o,     0);
    check("rst_freq",  freq_o,     0);
    check("rst_note",  note_on_o,  0);
    check("rst_busy",  busy_o,     0);
    #1 rst_n = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      hold(4);
      check("col_step", kpyd_col_o, exp_cols[k % 4]);
    end

    // One-scan glitch on key 6
    pressed = 16'h0040;
    hold(16);
    pressed = '0;
    hold(64);
    check("glitch_note", note_on_o, 0);
    check("glitch_gain", gain_o,    0);
    check("glitch_freq", freq_o,    0);

    // Steady press of row1/col2
    pressed = 16'h0040;
    n = 0;
    while (!note_on_o && n < 200) begin hold(1); n++; end
    check("commit_note", note_on_o, 1);
    hold(1);
    n = 1;
    check("commit_freq", freq_o, 6);
    check("commit_busy", busy_o, 1);
    while (gain_o != 8'd255 && n < 400) begin hold(1); n++; end
    check("attack_len", n, 256);
    hold(20);
    check("sustain_gain", gain_o, 255);

    // Release from sustain
    pressed = '0;
    n = 0;
    while (gain_o == 8'd255 && n < 200) begin hold(1); n++; end
    for (int k = 1; k <= 51; k++) begin
      check("release_ramp", gain_o, 255 - 5 * k);
      if (k < 51) hold(1);
    end
    check("release_busy", busy_o, 0);
    check("release_freq", freq_o, 6);

    // Keys 3 and 9 together, then drop 3
    pressed = 16'h0208;
    n = 0;
    while (gain_o != 8'd255 && n < 800) begin hold(1); n++; end
    check("dual_gain", gain_o, 255);
    check("dual_freq", freq_o, 3);
    pressed = 16'h0200;
    n = 0;
    while (freq_o != 4'd9 && n < 200) begin hold(1); n++; end
    check("legato_freq", freq_o, 9);
    check("legato_gain", gain_o, 255);

    // Randomised keypad activity
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0: pressed = '0;
        1: pressed = 16'(1 << $urandom_range(0, 15));
        2: pressed = 16'($urandom());
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) hold(300);
      else hold($urandom_range(1, 60));
    end

    // Reset mid-attack
    pressed = '0;
    n = 0;
    while (busy_o && n < 600) begin hold(1); n++; end
    check("idle_before_rst", busy_o, 0);
    pressed = 16'h0040;
    n = 0;
    while (gain_o != 8'd100 && n < 800) begin hold(1); n++; end
    check("reach_gain100", gain_o, 100);
    rst_n = 1'b0;
    #1;
    check("async_col",  kpyd_col_o, 4'b1110);
    check("async_gain", gain_o,     0);
    check("async_freq", freq_o,     0);
    check("async_note", note_on_o,  0);
    check("async_busy", busy_o,     0);
    hold(2);
    rst_n = 1'b1;
    hold(1);
    check("restart_col0", kpyd_col_o, 4'b1110);
    hold(4);
    check("restart_col1", kpyd_col_o, 4'b1101);
    pressed = '0;
    hold(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
